memory_stage: RTL
=================

# memory_stage

Data-memory stage of the five-stage RISC-V core, sitting between execute and writeback. Consumes the execute-stage bundle, performs RV32I loads/stores over a valid/ready data-memory port with byte-lane alignment and load extension, and registers the result into the `mem_to_wb_s` bundle read by writeback. Stalls upstream for the duration of any memory access and emits bubbles to writeback while stalled.

## Interface

- `ADDR_WIDTH`, 32: data-memory byte-address width; `dmem_addr` is word-aligned.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_to_mem`  in  `ex_to_mem_s`  fields: valid, alu_result[31:0], rs2_data[31:0], rd[4:0], reg_write, mem_read, mem_write, funct3[2:0].
- `mem_stall`  out  1  combinational; upstream holds `ex_to_mem` while high.
- `dmem_req_valid`  out  1  request valid.
- `dmem_req_ready`  in  1  request accepted when valid && ready.
- `dmem_addr`  out  ADDR_WIDTH  `{alu_result[ADDR_WIDTH-1:2], 2'b00}`.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_be`  out  4  byte enables (stores; 4'b0000 on loads).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rsp_valid`  in  1  load data valid (loads only).
- `dmem_rdata`  in  32  load word.
- `mem_to_wb`  out  `mem_to_wb_s`  registered {rd, reg_write, data}.
- `mem_fault`  out  1  registered one-cycle pulse: misaligned or illegal access.

## Operation

- FSM states: IDLE, REQ, WAIT_RSP, DONE. Op fields (addr, funct3, rs2, rd, reg_write, is_load) latched on IDLE->REQ.
- IDLE, `valid=0`: `mem_to_wb` <= bubble (reg_write=0, rd=0, data=0); no stall.
- IDLE, valid, neither mem_read nor mem_write: `mem_to_wb` <= {rd, reg_write, alu_result}; no stall.
- IDLE, valid, mem op, legal and aligned: `mem_stall=1`, latch op, -> REQ.
- Fault: mem_read && mem_write; funct3 not in {000,001,010} for stores or {000,001,010,100,101} for loads; halfword with addr[0]=1; word with addr[1:0]!=0. Response: no bus request, no stall, `mem_fault` pulses next cycle, `mem_to_wb` <= bubble.
- REQ: `dmem_req_valid=1`, all request fields stable until accepted. On ready: store -> DONE; load -> WAIT_RSP.
- WAIT_RSP: on `dmem_rsp_valid`, extract load value, latch -> DONE.
- DONE: `mem_stall=0`; `ex_to_mem` ignored (still the held op); `mem_to_wb` <= {rd, reg_write, load_value} for loads, bubble for stores; -> IDLE.
- REQ/WAIT_RSP: `mem_stall=1`; `mem_to_wb` <= bubble each cycle.
- Store lanes: SB wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0]; SW be=4'b1111.
- Load: word shifted right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- `dmem_rsp_valid` outside WAIT_RSP ignored.

## Timing

- Reset: state IDLE, `mem_to_wb` all zero, `dmem_req_valid=0`, `dmem_be=0`, `mem_fault=0`; `mem_stall` = 0 unless IDLE input is a legal mem op.
- Reset mid-access abandons it; late response after reset ignored; no writeback produced.
- Non-mem op: 1-cycle latency, no stall.
- Store with ready in first REQ cycle: 3 cycles (IDLE, REQ, DONE); result visible cycle after DONE.
- Load with ready immediately and response next cycle: 4 cycles. Response never accepted in the accept cycle.
- Back-to-back: next op sampled in IDLE the cycle after DONE.

## Structure

- `ex_to_mem_s` and funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) added to `riscv_structures.sv`; `mem_to_wb_s` unchanged.
- Sub-module `load_store_align`: purely combinational be/wdata generation, load extract/extend, misalignment/illegal detection. FSM and registers in `memory_stage`.

## Test plan

- ALU op alu_result=0x1234, rd=5, reg_write=1 -> next cycle mem_to_wb={5,1,0x1234}, mem_stall never high.
- SB rs2=0xAABBCCDD, addr=0x103, ready immediate -> be=4'b1000, wdata=0xDDDDDDDD, dmem_addr=0x100, stall 2 cycles, then bubble.
- LB addr=0x102, rdata=0x00F00000, ready after 2 cycles, rsp 3 cycles later -> data=0xFFFFFFF0; LBU same -> 0x000000F0; stall through all wait cycles.
- LH addr=0x101 -> no request, mem_fault one pulse, bubble, no stall; funct3=011 load -> same.
- Reset asserted in WAIT_RSP, rsp_valid next cycle -> IDLE, mem_to_wb zero, no fault, no writeback.
- SW then LW back-to-back, ready held low 4 cycles -> request fields stable, ordered completion, correct values.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared types for the data-memory stage: execute/writeback bundles and load/store funct3 codes.
package memory_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned BE_W       = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
  } ex_to_mem_s;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [XLEN-1:0]       data;
  } mem_to_wb_s;

  localparam mem_to_wb_s WB_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Combinational byte-lane logic: store enables/data, load extract/extend, access legality.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]      req_funct3,
  input  logic [1:0]      req_offset,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            req_mem_read,
  input  logic            req_mem_write,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            fault_c,
  input  logic [2:0]      rsp_funct3,
  input  logic [1:0]      rsp_offset,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] load_value_c
);

  logic            store_ok;
  logic            load_ok;
  logic            misaligned;
  logic [XLEN-1:0] shifted;

  // Store lane placement: narrow data is replicated so any lane can pick it up.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_rs2;
    case (req_funct3)
      F3_B: begin
        be_c    = 4'b0001 << req_offset;
        wdata_c = {4{req_rs2[7:0]}};
      end
      F3_H: begin
        be_c    = 4'b0011 << req_offset;
        wdata_c = {2{req_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Low funct3 bits encode access size for both signed and unsigned loads.
  always_comb begin
    store_ok   = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    load_ok    = store_ok || (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_offset[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_offset != 2'b00));
    fault_c    = (req_mem_read || req_mem_write) &&
                 ((req_mem_read && req_mem_write) ||
                  (req_mem_write && !store_ok) ||
                  (req_mem_read && !load_ok) ||
                  misaligned);
  end

  always_comb begin
    shifted      = rsp_rdata >> {rsp_offset, 3'b000};
    load_value_c = shifted;
    case (rsp_funct3)
      F3_B:    load_value_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_value_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_value_c = {24'b0, shifted[7:0]};
      F3_HU:   load_value_c = {16'b0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I data-memory stage: sequences one load/store at a time over a valid/ready port
// and registers the writeback bundle, stalling upstream while an access is in flight.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ex_to_mem_s            ex_to_mem,
  output logic                  mem_stall,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [BE_W-1:0]       dmem_be,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output mem_to_wb_s            mem_to_wb,
  output logic                  mem_fault
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_d;
  mem_to_wb_s            wb_d;
  logic                  fault_d;
  logic                  req_valid_d;
  logic                  latch_op;
  logic                  latch_rsp;

  logic [2:0]            op_funct3;
  logic [1:0]            op_offset;
  logic [REG_ADDR_W-1:0] op_rd;
  logic                  op_reg_write;
  logic                  op_is_load;
  logic [XLEN-1:0]       load_data;

  logic                  mem_op_c;
  logic                  start_c;
  logic [BE_W-1:0]       be_c;
  logic [XLEN-1:0]       wdata_c;
  logic                  fault_c;
  logic [XLEN-1:0]       load_value_c;

  load_store_align u_align (
    .req_funct3    (ex_to_mem.funct3),
    .req_offset    (ex_to_mem.alu_result[1:0]),
    .req_rs2       (ex_to_mem.rs2_data),
    .req_mem_read  (ex_to_mem.mem_read),
    .req_mem_write (ex_to_mem.mem_write),
    .be_c          (be_c),
    .wdata_c       (wdata_c),
    .fault_c       (fault_c),
    .rsp_funct3    (op_funct3),
    .rsp_offset    (op_offset),
    .rsp_rdata     (dmem_rdata),
    .load_value_c  (load_value_c)
  );

  assign mem_op_c  = ex_to_mem.valid && (ex_to_mem.mem_read || ex_to_mem.mem_write);
  assign start_c   = (state == ST_IDLE) && mem_op_c && !fault_c;
  assign mem_stall = start_c || (state == ST_REQ) || (state == ST_WAIT_RSP);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next state and next registered outputs; writeback defaults to a bubble.
  always_comb begin
    state_d     = state;
    wb_d        = WB_BUBBLE;
    fault_d     = 1'b0;
    req_valid_d = dmem_req_valid;
    latch_op    = 1'b0;
    latch_rsp   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_to_mem.valid) begin
          if (!mem_op_c) begin
            wb_d.rd        = ex_to_mem.rd;
            wb_d.reg_write = ex_to_mem.reg_write;
            wb_d.data      = ex_to_mem.alu_result;
          end else if (fault_c) begin
            fault_d = 1'b1;
          end else begin
            latch_op    = 1'b1;
            req_valid_d = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = op_is_load ? ST_WAIT_RSP : ST_DONE;
        end
      end
      ST_WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          latch_rsp = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (op_is_load) begin
          wb_d.rd        = op_rd;
          wb_d.reg_write = op_reg_write;
          wb_d.data      = load_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured once at issue so they stay stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      mem_to_wb      <= WB_BUBBLE;
      mem_fault      <= 1'b0;
      op_funct3      <= '0;
      op_offset      <= '0;
      op_rd          <= '0;
      op_reg_write   <= 1'b0;
      op_is_load     <= 1'b0;
      load_data      <= '0;
    end else begin
      dmem_req_valid <= req_valid_d;
      mem_to_wb      <= wb_d;
      mem_fault      <= fault_d;
      if (latch_op) begin
        dmem_addr    <= {ex_to_mem.alu_result[ADDR_WIDTH-1:2], 2'b00};
        dmem_we      <= ex_to_mem.mem_write;
        dmem_be      <= ex_to_mem.mem_write ? be_c : 4'b0000;
        dmem_wdata   <= wdata_c;
        op_funct3    <= ex_to_mem.funct3;
        op_offset    <= ex_to_mem.alu_result[1:0];
        op_rd        <= ex_to_mem.rd;
        op_reg_write <= ex_to_mem.reg_write;
        op_is_load   <= ex_to_mem.mem_read;
      end
      if (latch_rsp) load_data <= load_value_c;
    end
  end

endmodule
